// File: rtl/simd_issue_unit.sv
// Issue/writeback stage around a 4-lane 8-bit SIMD ALU: small vector register file,
// registered ALU operands, per-lane merge on writeback, and in-flight result forwarding.
module simd_issue_unit #(
   parameter int REG_ADDR_W = 2,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   input  logic [6+3*REG_ADDR_W-1:0]   instr,
   input  logic                        ld_en,
   input  logic [REG_ADDR_W-1:0]       ld_addr,
   input  logic [31:0]                 ld_data,
   output logic [31:0]                 vec_a,
   output logic [31:0]                 vec_b,
   output logic [3:0]                  mask,
   output logic [1:0]                  op,
   input  logic [31:0]                 alu_result,
   output logic                        wb_valid,
   output logic [REG_ADDR_W-1:0]       wb_addr,
   output logic [31:0]                 wb_data,
   output logic [CNT_W-1:0]            retire_count,
   input  logic [REG_ADDR_W-1:0]       dbg_addr,
   output logic [31:0]                 dbg_data
);

   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam int IW       = 6 + 3*REG_ADDR_W;

   logic [31:0]           rf [NUM_REGS];
   logic                  ex_valid;
   logic [REG_ADDR_W-1:0] ex_rd;

   logic [1:0]            dec_op;
   logic [3:0]            dec_mask;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic [REG_ADDR_W-1:0] dec_ra;
   logic [REG_ADDR_W-1:0] dec_rb;
   logic                  issue;
   logic [31:0]           merged;
   logic [31:0]           fwd_a;
   logic [31:0]           fwd_b;

   assign dec_op   = instr[IW-1 -: 2];
   assign dec_mask = instr[IW-3 -: 4];
   assign dec_rd   = instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
   assign dec_ra   = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
   assign dec_rb   = instr[REG_ADDR_W-1:0];

   assign instr_ready = ~ld_en;
   assign issue       = instr_valid & instr_ready;
   assign dbg_data    = rf[dbg_addr];

   // mask/op still describe the executing instruction until the next issue edge
   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? alu_result[8*i +: 8] : rf[ex_rd][8*i +: 8];
      end
   end

   assign fwd_a = (ex_valid && (dec_ra == ex_rd)) ? merged : rf[dec_ra];
   assign fwd_b = (ex_valid && (dec_rb == ex_rd)) ? merged : rf[dec_rb];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] <= '0;
         end
         ex_valid     <= 1'b0;
         ex_rd        <= '0;
         vec_a        <= '0;
         vec_b        <= '0;
         mask         <= '0;
         op           <= '0;
         wb_valid     <= 1'b0;
         wb_addr      <= '0;
         wb_data      <= '0;
         retire_count <= '0;
      end else begin
         ex_valid <= issue;
         if (issue) begin
            vec_a <= fwd_a;
            vec_b <= fwd_b;
            mask  <= dec_mask;
            op    <= dec_op;
            ex_rd <= dec_rd;
         end
         wb_valid <= ex_valid;
         if (ex_valid) begin
            rf[ex_rd]    <= merged;
            wb_addr      <= ex_rd;
            wb_data      <= merged;
            retire_count <= retire_count + CNT_W'(1);
         end
         // host load is the later assignment so it wins over a same-address writeback
         if (ld_en) begin
            rf[ld_addr] <= ld_data;
         end
      end
   end

endmodule
